// File: rtl/axis_differentiator_pipe_if.sv
// AXI4-Stream beat bundle (valid/ready/data) shared by the differentiator's
// input and output ports and by anything that drives or consumes them.
interface axis_differentiator_pipe_if #(
    parameter int W = 32
) ();
    logic         tvalid;
    logic         tready;
    logic [W-1:0] tdata;

    modport master (output tvalid, output tdata, input tready);
    modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/axis_differentiator_pipe.sv
// Back-pressured AXI4-Stream differentiator: bypass, first difference, central
// difference or 5-tap wideband, fixed two-register latency, saturating output.
module axis_differentiator_pipe #(
    parameter int AXIS_TDATA_WIDTH = 32
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [1:0]                        mode,
    axis_differentiator_pipe_if.slave         S_AXIS,
    axis_differentiator_pipe_if.master        M_AXIS,
    output logic                              overflow
);
    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int WD = W + 1;
    localparam int WP = W + 7;

    typedef enum logic [1:0] {
        MODE_BYPASS   = 2'd0,
        MODE_FIRST    = 2'd1,
        MODE_CENTRAL  = 2'd2,
        MODE_WIDEBAND = 2'd3
    } mode_t;

    logic signed [W-1:0]  r_x1, r_x2, r_x3, r_x4;

    logic                 r_s1Valid;
    logic signed [W-1:0]  r_s1X;
    logic signed [WD-1:0] r_s1D0;
    logic signed [WD-1:0] r_s1D1;
    logic signed [WD-1:0] r_s1Diff1;
    logic signed [WD-1:0] r_s1Diff2;
    mode_t                r_s1Mode;

    logic                 r_mValid;
    logic [W-1:0]         r_mData;
    logic                 r_overflow;

    logic                 w_advance;
    logic                 w_ready;
    logic                 w_accept;
    logic signed [W-1:0]  w_x;
    logic signed [WD-1:0] w_d0, w_d1, w_diff1, w_diff2;

    logic signed [WP-1:0] w_d0Ext, w_d1Ext;
    logic signed [WP-1:0] w_prod, w_scaled;
    logic signed [WD-1:0] w_half;
    logic signed [WP-1:0] w_ext;
    logic                 w_fits;
    logic [W-1:0]         w_satData;

    assign w_advance = ~r_mValid | M_AXIS.tready;
    assign w_ready   = aresetn & w_advance;
    assign w_accept  = S_AXIS.tvalid & w_ready;
    assign w_x       = S_AXIS.tdata;

    assign S_AXIS.tready = w_ready;
    assign M_AXIS.tvalid = r_mValid;
    assign M_AXIS.tdata  = r_mData;
    assign overflow      = r_overflow;

    // Differences carry one extra bit so no input pair can wrap.
    assign w_d0    = {w_x[W-1], w_x}   - {r_x4[W-1], r_x4};
    assign w_d1    = {r_x1[W-1], r_x1} - {r_x3[W-1], r_x3};
    assign w_diff1 = {w_x[W-1], w_x}   - {r_x1[W-1], r_x1};
    assign w_diff2 = {w_x[W-1], w_x}   - {r_x2[W-1], r_x2};

    // Wideband tap: 31*d1 - 6*d0 as shift-and-add, then a floor divide by 32.
    assign w_d0Ext  = {{(WP-WD){r_s1D0[WD-1]}}, r_s1D0};
    assign w_d1Ext  = {{(WP-WD){r_s1D1[WD-1]}}, r_s1D1};
    assign w_prod   = (w_d1Ext <<< 5) - w_d1Ext - (w_d0Ext <<< 2) - (w_d0Ext <<< 1);
    assign w_scaled = w_prod >>> 5;
    assign w_half   = r_s1Diff2 >>> 1;

    always_comb begin
        w_ext = '0;
        case (r_s1Mode)
            MODE_BYPASS:  w_ext = {{(WP-W){r_s1X[W-1]}}, r_s1X};
            MODE_FIRST:   w_ext = {{(WP-WD){r_s1Diff1[WD-1]}}, r_s1Diff1};
            MODE_CENTRAL: w_ext = {{(WP-WD){w_half[WD-1]}}, w_half};
            default:      w_ext = w_scaled;
        endcase
    end

    // A value fits in W bits exactly when every bit above the W-bit sign agrees with it.
    assign w_fits    = (w_ext[WP-1:W-1] == {(WP-W+1){w_ext[W-1]}});
    assign w_satData = w_fits ? w_ext[W-1:0]
                     : (w_ext[WP-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_x1       <= '0;
            r_x2       <= '0;
            r_x3       <= '0;
            r_x4       <= '0;
            r_s1Valid  <= 1'b0;
            r_s1X      <= '0;
            r_s1D0     <= '0;
            r_s1D1     <= '0;
            r_s1Diff1  <= '0;
            r_s1Diff2  <= '0;
            r_s1Mode   <= MODE_BYPASS;
            r_mValid   <= 1'b0;
            r_mData    <= '0;
            r_overflow <= 1'b0;
        end else if (w_advance) begin
            r_mValid  <= r_s1Valid;
            if (r_s1Valid) begin
                r_mData <= w_satData;
                if (!w_fits) begin
                    r_overflow <= 1'b1;
                end
            end
            r_s1Valid <= w_accept;
            if (w_accept) begin
                r_s1X     <= w_x;
                r_s1D0    <= w_d0;
                r_s1D1    <= w_d1;
                r_s1Diff1 <= w_diff1;
                r_s1Diff2 <= w_diff2;
                r_s1Mode  <= mode_t'(mode);
                r_x1      <= w_x;
                r_x2      <= r_x1;
                r_x3      <= r_x2;
                r_x4      <= r_x3;
            end
        end
    end
endmodule

// File: tb/tb_axis_differentiator_pipe.sv
// Self-checking bench: a W=32 lane and a W=16 lane, each watched every cycle
// against an arithmetic model of the differentiator, plus literal output lists.
module tb_axis_differentiator_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rstn[2];
    logic               sValid[2];
    logic signed [31:0] sData[2];
    logic [1:0]         sMode[2];
    logic               mReady[2];

    logic               mValidOut[2];
    logic signed [63:0] mDataOut[2];
    logic               sReadyOut[2];
    logic               ovfOut[2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit latChk = 1'b1;
    int expPending[2];

    typedef struct {
        int     lane;
        longint v;
    } logEntry_t;
    logEntry_t outLog[$];

    typedef struct {
        longint v;
        bit     clamp;
        int     t;
    } exp_t;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic longint floorDiv(longint a, longint d);
        longint qv;
        qv = a / d;
        if ((a % d) != 0 && ((a < 0) != (d < 0))) qv = qv - 1;
        return qv;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int W = (g == 0) ? 32 : 16;
        localparam longint SAT_MAX = (longint'(1) <<< (W - 1)) - 1;
        localparam longint SAT_MIN = -(longint'(1) <<< (W - 1));

        axis_differentiator_pipe_if #(.W(W)) sIf ();
        axis_differentiator_pipe_if #(.W(W)) mIf ();
        logic ovf;

        assign sIf.tvalid   = sValid[g];
        assign sIf.tdata    = sData[g][W-1:0];
        assign mIf.tready   = mReady[g];
        assign mValidOut[g] = mIf.tvalid;
        assign mDataOut[g]  = 64'($signed(mIf.tdata));
        assign sReadyOut[g] = sIf.tready;
        assign ovfOut[g]    = ovf;

        axis_differentiator_pipe #(.AXIS_TDATA_WIDTH(W)) dut (
            .aclk     (clk),
            .aresetn  (rstn[g]),
            .mode     (sMode[g]),
            .S_AXIS   (sIf),
            .M_AXIS   (mIf),
            .overflow (ovf)
        );

        exp_t   q[$];
        longint hist[4];
        bit     ovfModel;
        bit     stallPending;
        longint stallData;

        function automatic exp_t predict(longint x, logic [1:0] m, int t);
            exp_t   e;
            longint raw;
            case (m)
                2'd0:    raw = x;
                2'd1:    raw = x - hist[0];
                2'd2:    raw = floorDiv(x - hist[1], 2);
                default: raw = floorDiv(31 * (hist[0] - hist[2]) - 6 * (x - hist[3]), 32);
            endcase
            e.clamp = 1'b0;
            e.v     = raw;
            e.t     = t;
            if (raw > SAT_MAX) begin e.v = SAT_MAX; e.clamp = 1'b1; end
            if (raw < SAT_MIN) begin e.v = SAT_MIN; e.clamp = 1'b1; end
            return e;
        endfunction

        always @(negedge clk) begin
            exp_t   e;
            longint act;
            bit     expOvf;
            if (!rstn[g]) begin
                q.delete();
                hist          = '{default: 0};
                ovfModel      = 1'b0;
                stallPending  = 1'b0;
                expPending[g] = 0;
            end else begin
                act    = mDataOut[g];
                expOvf = ovfModel | (mValidOut[g] && q.size() > 0 && q[0].clamp);
                check($sformatf("lane%0d overflow", g), ovfOut[g], expOvf);
                if (stallPending) begin
                    check($sformatf("lane%0d stall valid", g), mValidOut[g], 1);
                    check($sformatf("lane%0d stall data", g), act, stallData);
                end
                if (mValidOut[g] && mReady[g]) begin
                    if (q.size() == 0) begin
                        check($sformatf("lane%0d unexpected beat", g), act, 64'hDEAD);
                    end else begin
                        e = q.pop_front();
                        expPending[g]--;
                        check($sformatf("lane%0d data", g), act, e.v);
                        if (latChk) check($sformatf("lane%0d latency", g), cyc - e.t, 2);
                        ovfModel |= e.clamp;
                    end
                    outLog.push_back('{g, act});
                end
                stallPending = mValidOut[g] && !mReady[g];
                stallData    = act;
                if (sValid[g] && sReadyOut[g]) begin
                    q.push_back(predict(longint'($signed(sIf.tdata)), sMode[g], cyc));
                    expPending[g]++;
                    hist[3] = hist[2];
                    hist[2] = hist[1];
                    hist[1] = hist[0];
                    hist[0] = longint'($signed(sIf.tdata));
                end
            end
        end
    end

    task automatic waitAccept(int ln);
        bit ok;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            ok = sReadyOut[ln];
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) check("accept timeout", 0, 1);
    endtask

    task automatic applyStimulus(int ln, logic [1:0] m, longint vals[$]);
        foreach (vals[i]) begin
            sValid[ln] = 1'b1;
            sData[ln]  = 32'(vals[i]);
            sMode[ln]  = m;
            waitAccept(ln);
        end
        sValid[ln] = 1'b0;
    endtask

    task automatic drain(int ln);
        sValid[ln] = 1'b0;
        mReady[ln] = 1'b1;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check($sformatf("lane%0d drained", ln), expPending[ln], 0);
    endtask

    task automatic checkOutput(int ln, string name, longint expv[$]);
        longint got[$];
        foreach (outLog[i]) if (outLog[i].lane == ln) got.push_back(outLog[i].v);
        check({name, " count"}, got.size(), expv.size());
        foreach (expv[i]) begin
            if (i < got.size()) check($sformatf("%s[%0d]", name, i), got[i], expv[i]);
        end
        outLog.delete();
    endtask

    task automatic resetLane(int ln);
        rstn[ln]   = 1'b0;
        sValid[ln] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset tvalid", mValidOut[ln], 0);
        check("reset tdata", mDataOut[ln], 0);
        check("reset overflow", ovfOut[ln], 0);
        check("reset tready", sReadyOut[ln], 0);
        @(posedge clk);
        #1;
        rstn[ln] = 1'b1;
        outLog.delete();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        longint stim[$];
        longint expv[$];
        longint bpVals[$];
        bit     bpDone;

        for (int i = 0; i < 2; i++) begin
            rstn[i] = 1'b0; sValid[i] = 1'b0; sData[i] = '0; sMode[i] = '0; mReady[i] = 1'b1;
            expPending[i] = 0;
        end
        @(posedge clk);
        #1;
        resetLane(0);
        resetLane(1);

        // First difference, back-to-back beats
        stim = {0, 10, 30, 60};
        applyStimulus(0, 2'd1, stim);
        drain(0);
        expv = {0, 10, 20, 30};
        checkOutput(0, "mode1 ramp", expv);
        check("mode1 overflow", ovfOut[0], 0);

        // Wideband impulse response
        resetLane(0);
        stim = {32, 0, 0, 0, 0, 0, 0, 0, 0};
        applyStimulus(0, 2'd3, stim);
        drain(0);
        expv = {-6, 31, 0, -31, 6, 0, 0, 0, 0};
        checkOutput(0, "mode3 impulse", expv);

        // Central difference ramp, then the floor case
        resetLane(0);
        stim = {0, 4, 8, 12, 16};
        applyStimulus(0, 2'd2, stim);
        drain(0);
        expv = {0, 2, 4, 4, 4};
        checkOutput(0, "mode2 ramp", expv);
        resetLane(0);
        stim = {0, -1};
        applyStimulus(0, 2'd2, stim);
        drain(0);
        expv = {0, -1};
        checkOutput(0, "mode2 floor", expv);

        // W=16 saturation and sticky overflow
        stim = {-32768, 32767, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        applyStimulus(1, 2'd1, stim);
        drain(1);
        expv = {-32768, 32767, -32767, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        checkOutput(1, "w16 sat", expv);
        check("w16 overflow sticky", ovfOut[1], 1);

        // Backpressure with random bubbles on both sides
        resetLane(0);
        latChk = 1'b0;
        bpDone = 1'b0;
        bpVals.delete();
        expv.delete();
        for (int i = 0; i < 40; i++) begin
            bpVals.push_back(longint'(i * 7 - (i % 3) * 100));
            expv.push_back(i == 0 ? bpVals[0] : bpVals[i] - bpVals[i-1]);
        end
        fork
            begin
                foreach (bpVals[i]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        sValid[0] = 1'b0;
                        @(posedge clk);
                        #1;
                    end
                    stim = {bpVals[i]};
                    applyStimulus(0, 2'd1, stim);
                end
                bpDone = 1'b1;
            end
            begin
                while (!bpDone) begin
                    @(posedge clk);
                    #1;
                    mReady[0] = 1'($urandom_range(0, 1));
                end
            end
        join
        drain(0);
        checkOutput(0, "backpressure", expv);
        latChk = 1'b1;

        // Mode switch from bypass to first difference at the fourth beat
        resetLane(0);
        stim = {0, 5, 10};
        applyStimulus(0, 2'd0, stim);
        stim = {15, 20, 25};
        applyStimulus(0, 2'd1, stim);
        drain(0);
        expv = {0, 5, 10, 5, 5, 5};
        checkOutput(0, "mode switch", expv);

        // Reset with two beats in flight
        resetLane(0);
        latChk = 1'b0;
        mReady[0] = 1'b0;
        stim = {100, 200};
        applyStimulus(0, 2'd1, stim);
        @(posedge clk);
        #1;
        rstn[0] = 1'b0;
        @(posedge clk);
        #1;
        rstn[0] = 1'b1;
        check("midreset tvalid", mValidOut[0], 0);
        check("midreset overflow", ovfOut[0], 0);
        mReady[0] = 1'b1;
        latChk = 1'b1;
        stim = {7};
        applyStimulus(0, 2'd1, stim);
        drain(0);
        expv = {7};
        checkOutput(0, "post reset", expv);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
